stream_mux: RTL
===============

# stream_mux

Parametrised N-to-1 registered stream multiplexer, successor to the team's fixed 16-bit 2:1 select mux. Selects one of N valid/ready input channels, by an explicit select index or by round-robin arbitration, and presents the winner through a single output register stage with full backpressure. Sits between producer datapaths and a shared consumer (bus, FIFO or ALU operand port).

## Interface
- WIDTH, 16, data width per channel
- N, 4, channel count; legal 2..16
- SW, $clog2(N), select/source index width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; combinational
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SW  channel index used when mode = 0
- out_data  output  WIDTH  registered winning data
- out_src  output  SW  registered index of the winning channel
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

## Operation
- Transfer on any port occurs when valid and ready are both high at a rising edge.
- load = !out_valid || out_ready.
- Grant (one-hot, at most one bit):
  - mode 0: grant[sel] = in_valid[sel]; sel >= N grants nothing.
  - mode 1: first valid channel searching last+1, last+2, ... wrapping modulo N; last = index of the most recent accepted channel.
- in_ready[i] = load && grant[i]; non-granted channels see in_ready = 0.
- On load with a grant: out_data, out_src <= winner; out_valid <= 1; in mode 1, last <= winner.
- On load with no grant: out_valid <= 0; out_data and out_src hold.
- When out_valid && !out_ready: out_data and out_src remain stable; all in_ready = 0.
- last updates only on accepted round-robin grants; fixed-mode transfers leave it unchanged.
- mode and sel are sampled every cycle; a change affects only the next grant and never the held output word.

## Timing
- Reset (async assert, sync release): out_valid = 0, out_data = 0, out_src = 0, last = N-1, so the first round-robin search starts at channel 0.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready stays high.
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready. There is no combinational path from in_data to any output.
- Simultaneous output drain and input accept in the same cycle is required; there is no bubble.
- Reset asserted mid-stream: out_valid drops immediately and the held word is discarded.
- Round-robin fairness: with all N channels continuously valid and out_ready high, the grant sequence is 0, 1, ..., N-1, 0, ...

## Structure
- Shared package stream_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1
  - the default width constant (16)
- One sub-module: rr_arbiter (parameter N; inputs req[N], last[SW]; outputs gnt[N], gnt_idx[SW]). It is purely combinational. The last pointer register lives in stream_mux.

## Test plan
- Reset, then mode 0, sel = 2, in_valid = 4'b0100, ch2 = 16'hBEEF, out_ready = 1 -> next cycle out_valid = 1, out_data = BEEF, out_src = 2.
- mode 0, sel = 1, only ch3 valid -> in_ready = 0, out_valid stays 0.
- mode 1, all four valid, out_ready = 1 for 8 cycles -> out_src sequence 0, 1, 2, 3, 0, 1, 2, 3.
- mode 1, ch1 and ch3 valid, out_ready held low for 3 cycles after the first word -> out_data stable, in_ready = 0. On release, ch3 is granted next, then ch1.
- Back-to-back traffic with out_ready = 1 -> one word per cycle with no gaps.
- Assert rst_n low while out_valid = 1 -> out_valid = 0 and out_data = 0 without waiting for a clock edge. After release, the first round-robin grant goes to channel 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream multiplexer and its arbiter.
package stream_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int DEFAULT_WIDTH = 16;

   // Channel index reached by stepping 'off' places past 'base' in a ring of n.
   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after 'last',
// wrapping modulo N. The pointer register itself lives in the caller.
module rr_arbiter
   import stream_pkg::*;
#(
   parameter int N = 4,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] gnt_idx
);

   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req[wrap_add(int'(last), k, N)]) begin
            found = 1'b1;
            gnt[wrap_add(int'(last), k, N)] = 1'b1;
            gnt_idx = SW'(wrap_add(int'(last), k, N));
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 registered stream multiplexer with fixed-select or round-robin
// channel choice and a single backpressured output register stage.
module stream_mux
   import stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = 4,
   localparam int SW   = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SW-1:0]        sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SW-1:0]        out_src,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SW-1:0]    out_src_q, out_src_d;
   logic             out_valid_q, out_valid_d;
   logic [SW-1:0]    last_q, last_d;

   logic [N-1:0]     rr_gnt;
   logic [SW-1:0]    rr_idx;
   logic [N-1:0]     fixed_gnt;
   logic [N-1:0]     grant;
   logic [SW-1:0]    win_idx;
   logic [WIDTH-1:0] win_data;
   logic             load;

   rr_arbiter #(.N(N)) u_arb (
      .req     (in_valid),
      .last    (last_q),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // An out-of-range select matches no channel and therefore grants nothing.
   always_comb begin
      fixed_gnt = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == SW'(i)) begin
            fixed_gnt[i] = in_valid[i];
         end
      end
   end

   always_comb begin
      grant   = fixed_gnt;
      win_idx = sel;
      if (mode == MODE_RR) begin
         grant   = rr_gnt;
         win_idx = rr_idx;
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            win_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign load     = !out_valid_q || out_ready;
   assign in_ready = {N{load}} & grant;

   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      last_d      = last_q;
      if (load) begin
         out_valid_d = |grant;
         if (|grant) begin
            out_data_d = win_data;
            out_src_d  = win_idx;
            if (mode == MODE_RR) begin
               last_d = win_idx;
            end
         end
      end
   end

   // Pointer resets to N-1 so the first round-robin search begins at channel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         last_q      <= SW'(N - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant));

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid_q && !out_ready |=> out_valid_q && $stable(out_data_q) && $stable(out_src_q));

endmodule
